// File: rtl/digtal_uart_rx16x.sv
// UART receiver driven by a 16x-baud strobe: mid-bit sampling, optional parity,
// one-cycle valid/parity/framing pulses.
module digtal_uart_rx16x #(
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 Clock,
  input  logic                 Reset_N,
  input  logic                 Baud16X,
  input  logic                 RXD,
  output logic [DATA_BITS-1:0] Data,
  output logic                 Data_Valid,
  output logic                 Parity_Error,
  output logic                 Frame_Error,
  output logic                 Busy
);

  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_IDLE
  } state_t;

  state_t               state_reg, state_next;
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                 baud_prev_reg;
  logic [3:0]           cnt_reg, cnt_next;
  logic [IDX_W-1:0]     idx_reg, idx_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic                 par_bit_reg, par_bit_next;
  logic [DATA_BITS-1:0] data_next;
  logic                 valid_next, perr_next, ferr_next;
  logic                 tick, rxs, par_mismatch;

  assign rxs  = sync_reg[SYNC_STAGES-1];
  assign tick = Baud16X & ~baud_prev_reg;
  assign Busy = (state_reg != S_IDLE);

  // Odd parity wants XOR(data, parity) = 1, even wants 0.
  always_comb begin
    par_mismatch = 1'b0;
    if (PARITY == 1)      par_mismatch = ~(^shift_reg ^ par_bit_reg);
    else if (PARITY == 2) par_mismatch = ^shift_reg ^ par_bit_reg;
  end

  always_ff @(posedge Clock or negedge Reset_N) begin
    if (!Reset_N) begin
      sync_reg      <= '1;
      baud_prev_reg <= 1'b0;
      state_reg     <= S_IDLE;
      cnt_reg       <= '0;
      idx_reg       <= '0;
      shift_reg     <= '0;
      par_bit_reg   <= 1'b0;
      Data          <= '0;
      Data_Valid    <= 1'b0;
      Parity_Error  <= 1'b0;
      Frame_Error   <= 1'b0;
    end else begin
      sync_reg      <= {sync_reg[SYNC_STAGES-2:0], RXD};
      baud_prev_reg <= Baud16X;
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      idx_reg       <= idx_next;
      shift_reg     <= shift_next;
      par_bit_reg   <= par_bit_next;
      Data          <= data_next;
      Data_Valid    <= valid_next;
      Parity_Error  <= perr_next;
      Frame_Error   <= ferr_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    idx_next     = idx_reg;
    shift_next   = shift_reg;
    par_bit_next = par_bit_reg;
    data_next    = Data;
    valid_next   = 1'b0;
    perr_next    = 1'b0;
    ferr_next    = 1'b0;
    if (tick) begin
      case (state_reg)
        S_IDLE: begin
          if (!rxs) begin
            state_next = S_START;
            cnt_next   = '0;
          end
        end
        S_START: begin
          if (cnt_reg == 4'd7) begin
            if (rxs) begin
              state_next = S_IDLE;
            end else begin
              state_next = S_DATA;
              cnt_next   = '0;
              idx_next   = '0;
            end
          end else begin
            cnt_next = cnt_reg + 4'd1;
          end
        end
        S_DATA: begin
          if (cnt_reg == 4'd15) begin
            shift_next[idx_reg] = rxs;
            cnt_next            = '0;
            if (idx_reg == IDX_W'(DATA_BITS - 1))
              state_next = (PARITY != 0) ? S_PARITY : S_STOP;
            else
              idx_next = idx_reg + 1'b1;
          end else begin
            cnt_next = cnt_reg + 4'd1;
          end
        end
        S_PARITY: begin
          if (cnt_reg == 4'd15) begin
            par_bit_next = rxs;
            state_next   = S_STOP;
            cnt_next     = '0;
          end else begin
            cnt_next = cnt_reg + 4'd1;
          end
        end
        S_STOP: begin
          if (cnt_reg == 4'd15) begin
            data_next = shift_reg;
            cnt_next  = '0;
            // A good stop bit frees the FSM mid-bit so the next start edge is caught.
            if (rxs) begin
              valid_next = 1'b1;
              perr_next  = par_mismatch;
              state_next = S_IDLE;
            end else begin
              ferr_next  = 1'b1;
              state_next = S_WAIT_IDLE;
            end
          end else begin
            cnt_next = cnt_reg + 4'd1;
          end
        end
        S_WAIT_IDLE: begin
          if (rxs) state_next = S_IDLE;
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_digtal_uart_rx16x.sv
// Scoreboard bench: stimulus pushes expected characters, a monitor pops and compares
// on every output pulse. DUT a has no parity, DUT b uses even parity.
`timescale 1ns/1ps
module tb_digtal_uart_rx16x;

  typedef struct packed {
    logic [7:0] data;
    logic       frame;
    logic       perr;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       baud = 1'b0;
  logic       rxd_a = 1'b1;
  logic       rxd_b = 1'b1;
  logic [7:0] data_a, data_b;
  logic       dv_a, pe_a, fe_a, busy_a;
  logic       dv_b, pe_b, fe_b, busy_b;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  int   vt_a[$];

  digtal_uart_rx16x #(.DATA_BITS(8), .PARITY(0), .SYNC_STAGES(2)) dut_a (
    .Clock(clk), .Reset_N(rst_n), .Baud16X(baud), .RXD(rxd_a),
    .Data(data_a), .Data_Valid(dv_a), .Parity_Error(pe_a),
    .Frame_Error(fe_a), .Busy(busy_a)
  );

  digtal_uart_rx16x #(.DATA_BITS(8), .PARITY(2), .SYNC_STAGES(2)) dut_b (
    .Clock(clk), .Reset_N(rst_n), .Baud16X(baud), .RXD(rxd_b),
    .Data(data_b), .Data_Valid(dv_b), .Parity_Error(pe_b),
    .Frame_Error(fe_b), .Busy(busy_b)
  );

  always #17 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Square wave of period 2 clocks -> one tick every 2 clocks, 32 clocks per bit.
  initial begin
    forever begin
      @(posedge clk);
      #1 baud = ~baud;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_line(input int d, input logic b);
    if (d == 0) rxd_a = b;
    else        rxd_b = b;
  endtask

  // Reference: data is what was sent, frame error iff stop bit is 0, parity error
  // (even parity, good stop only) iff XOR of data and parity bit is 1.
  task automatic send(input int d, input logic [7:0] v, input logic pbit, input logic stop);
    exp_t e;
    e.data  = v;
    e.frame = ~stop;
    e.perr  = (d == 1) && stop && ((^v ^ pbit) == 1'b1);
    if (d == 0) q_a.push_back(e);
    else        q_b.push_back(e);
    set_line(d, 1'b0);
    hold(32);
    for (int i = 0; i < 8; i++) begin
      set_line(d, v[i]);
      hold(32);
    end
    if (d == 1) begin
      set_line(d, pbit);
      hold(32);
    end
    set_line(d, stop);
    hold(32);
    set_line(d, 1'b1);
  endtask

  task automatic mon(input int d, input logic [7:0] data, input logic dv,
                     input logic pe, input logic fe);
    exp_t e;
    if (dv | pe | fe) begin
      if ((d == 0) ? (q_a.size() == 0) : (q_b.size() == 0)) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse dut=%0d data=%0h valid=%0b perr=%0b ferr=%0b required=no_pulse",
                 d, data, dv, pe, fe);
      end else begin
        e = (d == 0) ? q_a.pop_front() : q_b.pop_front();
        check("rx_data", 32'(data), 32'(e.data));
        check("rx_flags_valid_perr_ferr", 32'({dv, pe, fe}), 32'({~e.frame, e.perr, e.frame}));
        if (d == 0 && dv) vt_a.push_back(cyc);
        $display("rx dut=%0d cyc=%0d data=%02h valid=%0b perr=%0b ferr=%0b", d, cyc, data, dv, pe, fe);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon(0, data_a, dv_a, pe_a, fe_a);
      mon(1, data_b, dv_b, pe_b, fe_b);
    end
  end

  initial begin
    logic [7:0] v;
    logic       stop;
    logic       pbit;

    hold(5);
    check("reset_outputs_a", 32'({data_a, dv_a, pe_a, fe_a, busy_a}), 32'(0));
    check("reset_outputs_b", 32'({data_b, dv_b, pe_b, fe_b, busy_b}), 32'(0));
    rst_n = 1'b1;
    hold(40);

    // 1: single 8N1 character
    send(0, 8'hA5, 1'b0, 1'b1);
    check("busy_after_stop", 32'(busy_a), 32'(0));
    hold(32);

    // 2: back-to-back characters
    send(0, 8'h55, 1'b0, 1'b1);
    send(0, 8'h3C, 1'b0, 1'b1);
    if (vt_a.size() >= 2) check("b2b_spacing", 32'(vt_a[$] - vt_a[$-1]), 32'(320));
    else                  check("b2b_count", 32'(vt_a.size()), 32'(2));
    check("data_after_b2b", 32'(data_a), 32'(8'h3C));
    hold(32);

    // 3: short glitch is rejected as a false start
    rxd_a = 1'b0;
    hold(8);
    rxd_a = 1'b1;
    check("glitch_busy_rise", 32'(busy_a), 32'(1));
    hold(40);
    check("glitch_busy_fall", 32'(busy_a), 32'(0));
    check("glitch_data_held", 32'(data_a), 32'(8'h3C));

    // 4: framing error, busy held until the line returns high
    send(0, 8'hFF, 1'b0, 1'b0);
    check("ferr_busy_held", 32'(busy_a), 32'(1));
    hold(8);
    check("ferr_busy_release", 32'(busy_a), 32'(0));
    hold(32);

    // random traffic on the no-parity receiver
    for (int n = 0; n < 12; n++) begin
      v    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 3) != 0);
      send(0, v, 1'b0, stop);
      hold(stop ? 32 * $urandom_range(0, 2) : 32 + 32 * $urandom_range(0, 1));
    end

    // 5: even parity
    send(1, 8'h07, 1'b1, 1'b1);
    hold(16);
    send(1, 8'h07, 1'b0, 1'b1);
    check("parity_data", 32'(data_b), 32'(8'h07));
    hold(32);
    for (int n = 0; n < 8; n++) begin
      v    = 8'($urandom_range(0, 255));
      pbit = 1'($urandom_range(0, 1));
      stop = ($urandom_range(0, 4) != 0);
      send(1, v, pbit, stop);
      hold(stop ? 32 * $urandom_range(0, 1) : 64);
    end
    send(0, 8'h5A, 1'b0, 1'b1);
    hold(32);

    // 6: reset during bit 4 of 0xC3 aborts the frame
    v = 8'hC3;
    rxd_a = 1'b0;
    hold(32);
    for (int i = 0; i < 4; i++) begin
      rxd_a = v[i];
      hold(32);
    end
    rxd_a = v[4];
    hold(16);
    rst_n = 1'b0;
    #1;
    check("midframe_reset_outputs", 32'({data_a, dv_a, pe_a, fe_a, busy_a}), 32'(0));
    hold(3);
    rxd_a = 1'b1;
    hold(3);
    rst_n = 1'b1;
    hold(64);
    send(0, 8'h81, 1'b0, 1'b1);
    hold(32);

    // break: 20 bit times low gives exactly one framing error with zero data
    begin
      exp_t e;
      e.data = 8'h00; e.frame = 1'b1; e.perr = 1'b0;
      q_a.push_back(e);
    end
    rxd_a = 1'b0;
    hold(20 * 32);
    check("break_busy", 32'(busy_a), 32'(1));
    rxd_a = 1'b1;
    hold(64);
    check("break_data", 32'(data_a), 32'(8'h00));
    check("break_idle", 32'(busy_a), 32'(0));

    hold(100);
    check("pending_a", 32'(q_a.size()), 32'(0));
    check("pending_b", 32'(q_b.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
